// File: rtl/lpc_cycle_mbx_ctrl.sv
// LPC cycle mailbox and read-response sequencer with I/O window decode.
// Define LPC_MBX_TIMEOUT_EN to add the read-wait timeout counter.
module lpc_cycle_mbx_ctrl #(
  parameter logic [15:0] BASE_ADDR       = 16'h0000,
  parameter logic [15:0] WINDOW_SIZE     = 16'h0005,
  parameter int          FIFO_DEPTH_LOG2 = 2,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000,
  parameter logic [7:0]  TIMEOUT_DATA    = 8'hFF
) (
  input  logic                       lpc_lclk,
  input  logic                       lpc_lreset_n,
  input  logic [15:0]                lpc_addr_i,
  output logic                       addr_hit_o,
  input  logic                       cyc_ready_i,
  input  logic [31:0]                cyc_tdata_i,
  output logic [31:0]                mbx_data_o,
  output logic                       mbx_valid_o,
  output logic [FIFO_DEPTH_LOG2:0]   mbx_level_o,
  input  logic                       mbx_pop_i,
  output logic                       irq_o,
  input  logic                       rsp_valid_i,
  input  logic [7:0]                 rsp_data_i,
  output logic                       wait_o,
  output logic [7:0]                 din_o,
  output logic                       din_valid_o,
  output logic [2:0]                 status_o,
  input  logic                       status_clr_i
);

  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;
  localparam logic [N:0] FULL_CNT = (N+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  logic [16:0] addr_x;
  logic [16:0] lo_x;
  logic [16:0] hi_x;

  assign addr_x = {1'b0, lpc_addr_i};
  assign lo_x   = {1'b0, BASE_ADDR};
  assign hi_x   = lo_x + {1'b0, WINDOW_SIZE};
  assign addr_hit_o = (addr_x >= lo_x) && (addr_x < hi_x);

  logic [24:0]  mem_q [DEPTH];
  logic [N-1:0] wr_q;
  logic [N-1:0] rd_q;
  logic [N:0]   cnt_q;
  logic [N:0]   cnt_d;
  logic         irq_q;
  logic         empty;
  logic         full;
  logic         pop_ok;
  logic         push_ok;
  logic         drop;
  logic         unused_hi;

  assign unused_hi = ^cyc_tdata_i[31:25];

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop_ok  = mbx_pop_i && !empty;
  // A full FIFO still accepts a push when the head leaves the same cycle
  assign push_ok = cyc_ready_i && (!full || mbx_pop_i);
  assign drop    = cyc_ready_i && full && !mbx_pop_i;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + (N+1)'(1);
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - (N+1)'(1);
    end
  end

  always_ff @(posedge lpc_lclk) begin
    if (push_ok) begin
      mem_q[wr_q] <= cyc_tdata_i[24:0];
    end
  end

  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + N'(1);
      if (pop_ok)  rd_q <= rd_q + N'(1);
      cnt_q <= cnt_d;
      irq_q <= !empty;
    end
  end

  assign mbx_valid_o = !empty;
  assign mbx_level_o = cnt_q;
  assign mbx_data_o  = empty ? 32'h0 : {7'h0, mem_q[rd_q]};
  assign irq_o       = irq_q;

  state_e     state_q;
  logic       wait_q;
  logic [7:0] din_q;
  logic       dv_q;
  logic [2:0] st_q;
  logic [2:0] st_d;
  logic       rd_cyc;
  logic       tmo_fire;
  logic       tmo_set;

  assign rd_cyc = cyc_ready_i && !cyc_tdata_i[24];

`ifdef LPC_MBX_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign tmo_fire = (tmo_q == TIMEOUT_CYCLES - 16'd1);
`else
  assign tmo_fire = 1'b0;
`endif

  assign tmo_set = (state_q == S_WAIT) && !rsp_valid_i && tmo_fire;

  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      din_q   <= 8'h0;
      dv_q    <= 1'b0;
`ifdef LPC_MBX_TIMEOUT_EN
      tmo_q   <= 16'h0;
`endif
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rd_cyc) begin
            state_q <= S_WAIT;
            wait_q  <= 1'b1;
`ifdef LPC_MBX_TIMEOUT_EN
            tmo_q   <= 16'h0;
`endif
          end
        end
        S_WAIT: begin
          if (rsp_valid_i) begin
            din_q   <= rsp_data_i;
            dv_q    <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= S_RESP;
          end else if (tmo_fire) begin
            din_q   <= TIMEOUT_DATA;
            dv_q    <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= S_RESP;
          end else begin
`ifdef LPC_MBX_TIMEOUT_EN
            tmo_q   <= tmo_q + 16'd1;
`endif
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sets win over a simultaneous clear
  assign st_d = (status_clr_i ? 3'b000 : st_q)
              | {rd_cyc && (state_q != S_IDLE), tmo_set, drop};

  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      st_q <= 3'b000;
    end else begin
      st_q <= st_d;
    end
  end

  assign wait_o      = wait_q;
  assign din_o       = din_q;
  assign din_valid_o = dv_q;
  assign status_o    = st_q;

endmodule

// File: tb/tb_lpc_cycle_mbx_ctrl.sv
// Bench for lpc_cycle_mbx_ctrl: directed steps, then random traffic
// checked against a queue-based reference model.
module tb_lpc_cycle_mbx_ctrl;

  localparam logic [15:0] BASE = 16'hFFFE;
  localparam logic [15:0] WIN  = 16'h0002;
  localparam int          TMO  = 10;
`ifdef LPC_MBX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        hit;
  logic        cyc;
  logic [31:0] tdata;
  logic [31:0] mdata;
  logic        mvalid;
  logic [2:0]  level;
  logic        pop;
  logic        irq;
  logic        rsp;
  logic [7:0]  rspd;
  logic        wt;
  logic [7:0]  din;
  logic        dv;
  logic [2:0]  st;
  logic        clr;

  lpc_cycle_mbx_ctrl #(
    .BASE_ADDR(BASE),
    .WINDOW_SIZE(WIN),
    .FIFO_DEPTH_LOG2(2),
    .TIMEOUT_CYCLES(16'(TMO)),
    .TIMEOUT_DATA(8'hFF)
  ) dut (
    .lpc_lclk(clk),
    .lpc_lreset_n(rst_n),
    .lpc_addr_i(addr),
    .addr_hit_o(hit),
    .cyc_ready_i(cyc),
    .cyc_tdata_i(tdata),
    .mbx_data_o(mdata),
    .mbx_valid_o(mvalid),
    .mbx_level_o(level),
    .mbx_pop_i(pop),
    .irq_o(irq),
    .rsp_valid_i(rsp),
    .rsp_data_i(rspd),
    .wait_o(wt),
    .din_o(din),
    .din_valid_o(dv),
    .status_o(st),
    .status_clr_i(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  bit          pend;
  bit          cool;
  int          waited;
  logic [7:0]  e_din;
  bit          e_dv;
  bit          e_irq;
  logic [2:0]  e_st;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(logic [15:0] a);
    int lo;
    lo = int'(BASE);
    return (int'(a) >= lo) && (int'(a) < lo + int'(WIN));
  endfunction

  task automatic model_reset();
    mq.delete();
    pend   = 0;
    cool   = 0;
    waited = 0;
    e_din  = 8'h0;
    e_dv   = 0;
    e_irq  = 0;
    e_st   = 3'b000;
  endtask

  task automatic model_step();
    bit was_pend;
    bit was_cool;
    bit rd;
    logic [2:0] set;
    set      = 3'b000;
    e_irq    = (mq.size() != 0);
    if (pop && mq.size() != 0) void'(mq.pop_front());
    if (cyc) begin
      if (mq.size() < 4) mq.push_back({7'h0, tdata[24:0]});
      else set[0] = 1'b1;
    end
    was_pend = pend;
    was_cool = cool;
    cool     = 0;
    e_dv     = 0;
    if (was_pend) begin
      waited++;
      if (rsp) begin
        e_din = rspd;
        e_dv  = 1;
      end else if (TMO_EN && waited == TMO) begin
        e_din  = 8'hFF;
        e_dv   = 1;
        set[1] = 1'b1;
      end
      if (e_dv) begin
        pend = 0;
        cool = 1;
      end
    end
    rd = cyc && !tdata[24];
    if (rd) begin
      if (was_pend || was_cool) begin
        set[2] = 1'b1;
      end else begin
        pend   = 1;
        waited = 0;
      end
    end
    e_st = (clr ? 3'b000 : e_st) | set;
  endtask

  task automatic compare_all();
    chk("valid", 32'(mvalid), 32'(mq.size() != 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("data", mdata, mq.size() != 0 ? mq[0] : 32'h0);
    chk("irq", 32'(irq), 32'(e_irq));
    chk("wait", 32'(wt), 32'(pend));
    chk("din", 32'(din), 32'(e_din));
    chk("din_valid", 32'(dv), 32'(e_dv));
    chk("status", 32'(st), 32'(e_st));
    chk("addr_hit", 32'(hit), 32'(m_hit(addr)));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    cyc = 0; pop = 0; rsp = 0; clr = 0;
  endtask

  logic [15:0] sweep[6];

  initial begin
    rst_n = 0; addr = 16'h0; tdata = 32'h0; rspd = 8'h0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;

    // Write record, irq latency, pop
    cyc = 1; tdata = 32'h0100_AB80;
    tick();
    idle_in();
    chk("wr_valid", 32'(mvalid), 32'h1);
    chk("wr_data", mdata, 32'h0100_AB80);
    chk("wr_irq0", 32'(irq), 32'h0);
    tick();
    chk("wr_irq1", 32'(irq), 32'h1);
    chk("wr_wait", 32'(wt), 32'h0);
    pop = 1;
    tick();
    idle_in();
    chk("pop_valid", 32'(mvalid), 32'h0);
    chk("pop_irq1", 32'(irq), 32'h1);
    tick();
    chk("pop_irq0", 32'(irq), 32'h0);

    // Read answered five cycles later
    cyc = 1; tdata = 32'h0000_0081;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("rd_wait", 32'(wt), 32'h1);
      tick();
    end
    chk("rd_wait5", 32'(wt), 32'h1);
    rsp = 1; rspd = 8'h5A;
    tick();
    idle_in();
    chk("rd_dv", 32'(dv), 32'h1);
    chk("rd_din", 32'(din), 32'h5A);
    chk("rd_wait0", 32'(wt), 32'h0);
    tick();
    chk("rd_dv0", 32'(dv), 32'h0);
    pop = 1;
    tick();
    idle_in();

    // Overflow then push/pop at full
    for (int i = 0; i < 5; i++) begin
      cyc = 1; tdata = 32'h0100_0000 | 32'(i * 16'h1111);
      tick();
    end
    idle_in();
    chk("ovf_level", 32'(level), 32'h4);
    chk("ovf_flag", 32'(st[0]), 32'h1);
    chk("ovf_head", mdata, 32'h0100_0000);
    for (int i = 0; i < 8; i++) begin
      cyc = 1; pop = 1;
      tdata = 32'hFE00_0000 | 32'h0100_0000 | 32'(i + 8'h40);
      tick();
      chk("pp_level", 32'(level), 32'h4);
    end
    idle_in();
    chk("pp_head", mdata, 32'h0100_0044);
    clr = 1; pop = 1;
    tick();
    idle_in();
    chk("clr_ovf", 32'(st[0]), 32'h0);
    pop = 1;
    repeat (3) tick();
    idle_in();
    chk("drained", 32'(mvalid), 32'h0);

    // Unanswered read
    cyc = 1; tdata = 32'h0000_0090;
    tick();
    idle_in();
    for (int i = 1; i < TMO; i++) tick();
    chk("to_wait", 32'(wt), 32'h1);
    if (TMO_EN) begin
      tick();
      chk("to_dv", 32'(dv), 32'h1);
      chk("to_din", 32'(din), 32'hFF);
      chk("to_flag", 32'(st[1]), 32'h1);
      clr = 1;
      tick();
      idle_in();
      chk("to_clr", 32'(st[1]), 32'h0);
    end else begin
      repeat (10) tick();
      chk("no_to_wait", 32'(wt), 32'h1);
      rsp = 1; rspd = 8'h33;
      tick();
      idle_in();
      chk("late_dv", 32'(dv), 32'h1);
    end
    tick();
    pop = 1;
    tick();
    idle_in();

    // Window at top of address space
    sweep[0] = 16'hFFFC; sweep[1] = 16'hFFFD;
    sweep[2] = 16'hFFFE; sweep[3] = 16'hFFFF;
    sweep[4] = 16'h0000; sweep[5] = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      addr = sweep[i];
      #1;
      chk("sweep", 32'(hit), 32'(m_hit(addr)));
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc   = ($urandom % 4) == 0;
      tdata = $urandom;
      pop   = ($urandom % 3) == 0;
      rsp   = ($urandom % 5) == 0;
      rspd  = 8'($urandom);
      clr   = ($urandom % 10) == 0;
      addr  = ($urandom % 2) != 0 ?
              16'hFFF0 + 16'($urandom % 16) : 16'($urandom);
      tick();
    end
    idle_in();
    rsp = 1;
    repeat (3) tick();
    idle_in();

    // Reset while a read is pending
    cyc = 1; tdata = 32'h0000_0085;
    tick();
    idle_in();
    tick();
    chk("pre_rst_wait", 32'(wt), 32'h1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_wait", 32'(wt), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_valid", 32'(mvalid), 32'h0);
    model_reset();
    #2;
    rst_n = 1;
    rsp = 1; rspd = 8'h77;
    tick();
    idle_in();
    chk("rst_no_dv", 32'(dv), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
